float_recip_arbiter: RTL and testbench
======================================

FLOAT_RECIP_ARBITER -- requirements
Module: float_recip_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (IEEE-754 single).
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum RUN cycles waiting for rcp_ack.
REQ-004 SHALL have port clk_p  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester request, held until that requester's done pulse.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  operand of requester i in bits [i*DATA_WIDTH +: DATA_WIDTH], stable while req[i]=1.
REQ-008 SHALL have port done  output  NUM_REQ  one-cycle completion pulse, one-hot.
REQ-009 SHALL have port rsp_data  output  DATA_WIDTH  1/operand, valid in the done cycle and held until the next done.
REQ-010 SHALL have port rsp_dbz  output  1  divide-by-zero flag, qualified by done.
REQ-011 SHALL have port rsp_timeout  output  1  timeout flag, qualified by done.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port rcp_number  output  DATA_WIDTH  operand driven to the shared reciprocal unit.
REQ-014 SHALL have port rcp_enable  output  1  reciprocal unit enable; low clears its iteration and ack.
REQ-015 SHALL have port rcp_result  input  DATA_WIDTH  reciprocal unit result.
REQ-016 SHALL have port rcp_ack  input  1  reciprocal unit convergence flag.

Function
REQ-017 SHALL implement states IDLE, ISSUE, RUN, DONE; rcp_enable=1 only in RUN.
REQ-018 SHALL, in IDLE with any req bit set, grant round-robin: first set bit at or after rr_ptr (wrapping), then set rr_ptr = granted index + 1 mod NUM_REQ.
REQ-019 SHALL latch the granted index and operand into registers at grant; rcp_number SHALL be driven from that register only.
REQ-020 SHALL, at grant, if operand exponent field [30:23]==0 (zero/denormal), bypass the unit: go IDLE->DONE, rsp_data = {sign, 8'hFF, 23'h0}, rsp_dbz=1.
REQ-021 SHALL otherwise go IDLE->ISSUE; ISSUE lasts exactly one cycle with rcp_enable=0 so the unit reloads its seed, then ->RUN.
REQ-022 SHALL, in RUN, clear a timeout counter on entry and increment it each cycle; rcp_ack sampled at the rising edge.
REQ-023 SHALL, on rcp_ack=1 in RUN, capture rsp_data=rcp_result, flags 0, ->DONE.
REQ-024 SHALL, if the counter reaches TIMEOUT without rcp_ack, capture rsp_data=32'h7FC00000, rsp_timeout=1, ->DONE; ack and timeout in the same cycle SHALL resolve to ack.
REQ-025 SHALL, in DONE, assert done[granted]=1 for exactly one cycle with rcp_enable=0, then ->IDLE.
REQ-026 SHALL achieve latency grant->done of 3 cycles + RUN cycles (bypass: 1 cycle).
REQ-027 SHALL not arbitrate in DONE; a req still high in the IDLE cycle after done SHALL be treated as a new request.
REQ-028 SHALL ignore req deassertion after grant; the operation completes and done still pulses.
REQ-029 SHALL ignore rcp_ack outside RUN.

Reset
REQ-030 SHALL, on rst_n=0, asynchronously force state=IDLE, rr_ptr=0, done=0, rsp_data=0, rsp_dbz=0, rsp_timeout=0, busy=0, rcp_enable=0, rcp_number=0, counter=0.
REQ-031 SHALL, on reset mid-operation, abandon the operation with no done pulse; after release resume arbitration from rr_ptr=0.

Verification
REQ-032 SHALL cover: req[0]=1, operand 32'h40000000, model converges -> done[0] pulse, rsp_data=32'h3F000000, flags 0, rcp_enable low in ISSUE.
REQ-033 SHALL cover: req[2]=1, operand 32'h80000000 -> done[2] one cycle after grant, rsp_data=32'hFF800000, rsp_dbz=1, rcp_enable never high.
REQ-034 SHALL cover: req=4'b1111 held after reset, each dropped after its done -> done order 0,1,2,3; then req[0] and req[3] together -> 0 served first.
REQ-035 SHALL cover: model holds rcp_ack=0 -> done after 16 RUN cycles, rsp_data=32'h7FC00000, rsp_timeout=1; next request serviced normally.
REQ-036 SHALL cover: rst_n=0 during RUN -> rcp_enable=0, busy=0 immediately, no done pulse; subsequent 32'h3F800000 returns 32'h3F800000.

Source files
------------

// File: rtl/float_recip_arbiter.sv
// float_recip_arbiter
//   Shares one iterative floating-point reciprocal unit among NUM_REQ
//   requesters. Requests are granted round-robin. Zero and denormal operands
//   skip the unit and return a signed infinity with the divide-by-zero flag set.
//   If the unit does not converge within TIMEOUT RUN cycles, the operation ends
//   with a quiet NaN and the timeout flag set.
//
// Ports
//   clk_p        rising-edge clock
//   rst_n        asynchronous active-low reset
//   req          per-requester request, held until that requester's done
//   req_data     operand of requester i in [i*DATA_WIDTH +: DATA_WIDTH]
//   done         one-hot completion pulse, one cycle wide
//   rsp_data     1/operand; valid with done and held until the next done
//   rsp_dbz      divide-by-zero flag, qualified by done
//   rsp_timeout  timeout flag, qualified by done
//   busy         high in any state other than IDLE
//   rcp_number   operand to the reciprocal unit (registered)
//   rcp_enable   reciprocal unit enable; high only in RUN
//   rcp_result   reciprocal unit result
//   rcp_ack      reciprocal unit convergence flag
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | arbitrate; on a grant, latch the requester index and operand
// ST_ISSUE | one cycle with the unit disabled so that it reloads its seed
// ST_RUN   | unit enabled; wait for rcp_ack or for the timeout count
// ST_DONE  | pulse done[granted] for one cycle; unit disabled

module float_recip_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk_p,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_dbz,
  output logic                          rsp_timeout,
  output logic                          busy,
  output logic [DATA_WIDTH-1:0]         rcp_number,
  output logic                          rcp_enable,
  input  logic [DATA_WIDTH-1:0]         rcp_result,
  input  logic                          rcp_ack
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] QNAN = DATA_WIDTH'(32'h7FC0_0000);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        grant_idx;
  logic [DATA_WIDTH-1:0]   operand;
  logic [CNT_W-1:0]        run_cnt;

  logic [DATA_WIDTH-1:0]   op_arr [NUM_REQ];
  logic                    any_req;
  logic [PTR_W-1:0]        grant_sel;
  logic [PTR_W:0]          scan_sum;
  logic [DATA_WIDTH-1:0]   grant_op;
  logic                    grant_zero;
  logic                    tmo_hit;
  logic [PTR_W-1:0]        rr_nxt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_op
    assign op_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin scan: first set request at or after rr_ptr, wrapping.
  always_comb begin
    any_req   = 1'b0;
    grant_sel = '0;
    scan_sum  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (scan_sum >= (PTR_W+1)'(NUM_REQ))
        scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
      if (!any_req && req[scan_sum[PTR_W-1:0]]) begin
        any_req   = 1'b1;
        grant_sel = scan_sum[PTR_W-1:0];
      end
    end
  end

  assign grant_op   = op_arr[grant_sel];
  // A zero exponent field (zero or denormal) would overflow 1/x, so it bypasses the unit.
  assign grant_zero = (grant_op[DATA_WIDTH-2 -: 8] == 8'h00);
  assign tmo_hit    = (run_cnt == CNT_W'(TIMEOUT - 1));
  assign rr_nxt     = (grant_sel == PTR_W'(NUM_REQ - 1)) ? '0 : grant_sel + 1'b1;

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != ST_IDLE);
    rcp_enable = (state == ST_RUN);
    done       = '0;
    case (state)
      ST_IDLE:  if (any_req) state_nxt = grant_zero ? ST_DONE : ST_ISSUE;
      ST_ISSUE: state_nxt = ST_RUN;
      ST_RUN:   if (rcp_ack || tmo_hit) state_nxt = ST_DONE;
      ST_DONE: begin
        state_nxt = ST_IDLE;
        for (int i = 0; i < NUM_REQ; i++)
          done[i] = (grant_idx == PTR_W'(i));
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      grant_idx   <= '0;
      operand     <= '0;
      run_cnt     <= '0;
      rsp_data    <= '0;
      rsp_dbz     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_idx <= grant_sel;
            operand   <= grant_op;
            rr_ptr    <= rr_nxt;
            if (grant_zero) begin
              rsp_data    <= {grant_op[DATA_WIDTH-1], 8'hFF, {(DATA_WIDTH-9){1'b0}}};
              rsp_dbz     <= 1'b1;
              rsp_timeout <= 1'b0;
            end
          end
        end
        ST_ISSUE: run_cnt <= '0;
        ST_RUN: begin
          // Ack wins over a timeout landing in the same cycle.
          if (rcp_ack) begin
            rsp_data    <= rcp_result;
            rsp_dbz     <= 1'b0;
            rsp_timeout <= 1'b0;
          end else if (tmo_hit) begin
            rsp_data    <= QNAN;
            rsp_dbz     <= 1'b0;
            rsp_timeout <= 1'b1;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rcp_number = operand;

endmodule

// File: tb/tb_float_recip_arbiter.sv
// Self-checking bench for float_recip_arbiter: behavioural reciprocal unit
// with programmable convergence latency, and a scoreboard of expected completions.
module tb_float_recip_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;

  logic           clk_p;
  logic           rst_n;
  logic [NR-1:0]  req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  done;
  logic [DW-1:0]  rsp_data;
  logic           rsp_dbz;
  logic           rsp_timeout;
  logic           busy;
  logic [DW-1:0]  rcp_number;
  logic           rcp_enable;
  logic [DW-1:0]  rcp_result;
  logic           rcp_ack;

  float_recip_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(16)) dut (
    .clk_p       (clk_p),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .done        (done),
    .rsp_data    (rsp_data),
    .rsp_dbz     (rsp_dbz),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .rcp_number  (rcp_number),
    .rcp_enable  (rcp_enable),
    .rcp_result  (rcp_result),
    .rcp_ack     (rcp_ack)
  );

  initial clk_p = 1'b0;
  always #5 clk_p = ~clk_p;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reciprocal unit model: exact reciprocals for the operands used here.
  function automatic logic [31:0] recip_ref(input logic [31:0] op);
    case (op)
      32'h4000_0000: return 32'h3F00_0000;
      32'h3F80_0000: return 32'h3F80_0000;
      32'h3F00_0000: return 32'h4000_0000;
      32'h4080_0000: return 32'h3E80_0000;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  int ack_lat = 1;
  int iter;
  always @(posedge clk_p or negedge rst_n) begin
    if (!rst_n)           iter <= 0;
    else if (!rcp_enable) iter <= 0;
    else                  iter <= iter + 1;
  end
  assign rcp_ack    = rcp_enable && (iter >= ack_lat);
  assign rcp_result = recip_ref(rcp_number);

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        dbz;
    logic        tmo;
    int          run;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur_e;
  int          run_cnt = 0;
  logic [31:0] last_data = '0;

  always @(negedge clk_p) begin
    if (done != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", done, 0);
      end else begin
        cur_e = sb.pop_front();
        chk("done_vec", done, 64'd1 << cur_e.idx);
        chk("rsp_data", rsp_data, cur_e.data);
        chk("rsp_dbz", rsp_dbz, cur_e.dbz);
        chk("rsp_timeout", rsp_timeout, cur_e.tmo);
        chk("run_cycles", run_cnt, cur_e.run);
        chk("done_en_low", rcp_enable, 0);
        last_data = cur_e.data;
        req[cur_e.idx] = 1'b0;
      end
      run_cnt = 0;
    end else if (rcp_enable) begin
      run_cnt++;
    end
  end

  task automatic push_exp(input int idx, input logic [31:0] d, input logic dbz,
                          input logic tmo, input int run);
    exp_t e;
    e.idx = idx; e.data = d; e.dbz = dbz; e.tmo = tmo; e.run = run;
    sb.push_back(e);
  endtask

  task automatic set_req(input int idx, input logic [31:0] op);
    req_data[idx*DW +: DW] = op;
    req[idx] = 1'b1;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((sb.size() != 0 || req != '0) && i < 300) begin
      @(negedge clk_p);
      i++;
    end
    chk("drain_bound", (i < 300), 1);
    repeat (2) @(negedge clk_p);
    chk("rsp_hold", rsp_data, last_data);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(negedge clk_p);
    rst_n = 1'b1;
    run_cnt = 0;
    @(negedge clk_p);
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 50 && !busy; i++) @(negedge clk_p);
    chk("busy_seen", busy, 1);
  endtask

  task automatic wait_en();
    for (int i = 0; i < 50 && !rcp_enable; i++) @(negedge clk_p);
    chk("enable_seen", rcp_enable, 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    reset_dut();

    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", rcp_enable, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_dbz", rsp_dbz, 0);
    chk("rst_tmo", rsp_timeout, 0);
    chk("rst_num", rcp_number, 0);

    // Normal conversion: 2.0 -> 0.5, unit disabled during ISSUE
    ack_lat = 2;
    push_exp(0, 32'h3F00_0000, 0, 0, 3);
    set_req(0, 32'h4000_0000);
    wait_busy();
    chk("issue_en", rcp_enable, 0);
    chk("issue_num", rcp_number, 32'h4000_0000);
    @(negedge clk_p);
    chk("run_en", rcp_enable, 1);
    drain();

    // Zero operand bypass: -0.0 -> -inf, done the cycle after grant
    push_exp(2, 32'hFF80_0000, 1, 0, 0);
    set_req(2, 32'h8000_0000);
    @(negedge clk_p);
    chk("bypass_done", done, 4'b0100);
    drain();

    // Round-robin from rr_ptr=0 with all four requesting
    reset_dut();
    ack_lat = 1;
    push_exp(0, 32'h3F80_0000, 0, 0, 2);
    push_exp(1, 32'h3F00_0000, 0, 0, 2);
    push_exp(2, 32'h4000_0000, 0, 0, 2);
    push_exp(3, 32'h3E80_0000, 0, 0, 2);
    set_req(0, 32'h3F80_0000);
    set_req(1, 32'h4000_0000);
    set_req(2, 32'h3F00_0000);
    set_req(3, 32'h4080_0000);
    drain();
    push_exp(0, 32'h3F00_0000, 0, 0, 2);
    push_exp(3, 32'h4000_0000, 0, 0, 2);
    set_req(0, 32'h4000_0000);
    set_req(3, 32'h3F00_0000);
    drain();

    // Unit never converges: timeout after 16 RUN cycles, then normal service
    ack_lat = 1000;
    push_exp(1, 32'h7FC0_0000, 0, 1, 16);
    set_req(1, 32'h3F80_0000);
    drain();
    ack_lat = 1;
    push_exp(1, 32'h4000_0000, 0, 0, 2);
    set_req(1, 32'h3F00_0000);
    drain();

    // Reset during RUN: abandon silently, arbitration restarts at 0
    ack_lat = 1000;
    set_req(1, 32'h4080_0000);
    wait_en();
    repeat (3) @(negedge clk_p);
    #2;
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("mid_rst_en", rcp_enable, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_data", rsp_data, 0);
    repeat (2) @(negedge clk_p);
    rst_n = 1'b1;
    run_cnt = 0;
    @(negedge clk_p);
    ack_lat = 1;
    push_exp(1, 32'h3F80_0000, 0, 0, 2);
    push_exp(3, 32'h3E80_0000, 0, 0, 2);
    set_req(1, 32'h3F80_0000);
    set_req(3, 32'h4080_0000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $fatal(1);
  end

endmodule
